// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue
//  Description : Issue-side instruction queue. Accepts raw SPARC V8 words
//                from fetch, decodes format-3 arithmetic words into
//                operator / register / immediate fields and buffers them in
//                a DEPTH-entry FIFO whose head feeds the issue stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_inst_valid,
    input  logic [31:0]      in_inst,
    output logic             out_inst_ready,
    input  logic             in_flush,
    input  logic             in_fetch_next,
    output logic             out_valid,
    output logic [5:0]       out_operator_type,
    output logic [4:0]       out_reg_1,
    output logic [4:0]       out_reg_2,
    output logic [4:0]       out_reg_3,
    output logic             out_imm_valid,
    output logic [31:0]      out_imm_val,
    output logic             out_drop,
    output logic [PTR_W:0]   out_count
);

    // Count value meaning "every slot occupied".
    localparam logic [PTR_W:0]   c_FULL     = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ZERO = '0;
    localparam logic [PTR_W:0]   c_CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);
    // Top two bits of a format-3 arithmetic instruction.
    localparam logic [1:0]       c_OP_ARITH = 2'b10;

    // ------------------------------------------------------------------
    // Queue state
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_drop;

    // Per-field storage; one slot per queue entry.
    logic [5:0]       r_op_mem   [DEPTH];
    logic [4:0]       r_rs1_mem  [DEPTH];
    logic [4:0]       r_rs2_mem  [DEPTH];
    logic [4:0]       r_rd_mem   [DEPTH];
    logic             r_immv_mem [DEPTH];
    logic [31:0]      r_imm_mem  [DEPTH];

    // ------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_ready;
    logic w_push;
    logic w_is_arith;
    logic w_store;
    logic w_pop;

    // Ready ignores the pop request on purpose: a full queue never takes a
    // new word, even when the head is leaving in the same cycle.
    assign w_empty    = (r_count == c_CNT_ZERO);
    assign w_ready    = (r_count != c_FULL) && !in_flush;
    assign w_push     = in_inst_valid && w_ready;
    assign w_is_arith = (in_inst[31:30] == c_OP_ARITH);
    assign w_store    = w_push && w_is_arith && !reset;
    assign w_pop      = in_fetch_next && !w_empty && !in_flush;

    assign out_inst_ready = w_ready;
    assign out_count      = r_count;
    assign out_drop       = r_drop;

    // ------------------------------------------------------------------
    // Format-3 field decode of the incoming word
    // ------------------------------------------------------------------
    logic [5:0]  w_dec_op3;
    logic [4:0]  w_dec_rs1;
    logic [4:0]  w_dec_rs2;
    logic [4:0]  w_dec_rd;
    logic        w_dec_i;
    logic [31:0] w_dec_imm;

    // Split the word into fields; register and immediate forms are exclusive.
    always_comb begin
        w_dec_op3 = in_inst[24:19];
        w_dec_rd  = in_inst[29:25];
        w_dec_rs1 = in_inst[18:14];
        w_dec_i   = in_inst[13];
        w_dec_rs2 = 5'd0;
        w_dec_imm = 32'd0;
        if (w_dec_i) begin
            w_dec_imm = {{19{in_inst[12]}}, in_inst[12:0]};
        end else begin
            w_dec_rs2 = in_inst[4:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Pointer and occupancy tracking; flush discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (in_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_store && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_store && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Entry storage; contents need no reset because empty slots are masked.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_op_mem[r_wr_ptr]   <= w_dec_op3;
            r_rs1_mem[r_wr_ptr]  <= w_dec_rs1;
            r_rs2_mem[r_wr_ptr]  <= w_dec_rs2;
            r_rd_mem[r_wr_ptr]   <= w_dec_rd;
            r_immv_mem[r_wr_ptr] <= w_dec_i;
            r_imm_mem[r_wr_ptr]  <= w_dec_imm;
        end
    end

    // One-cycle pulse for every accepted word that is not arithmetic.
    always_ff @(posedge clk) begin
        if (reset || in_flush) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_push && !w_is_arith;
        end
    end

    // ------------------------------------------------------------------
    // Head presentation
    // ------------------------------------------------------------------

    // Head entry straight from storage, zeroed while the queue is empty.
    always_comb begin
        out_valid         = 1'b0;
        out_operator_type = 6'd0;
        out_reg_1         = 5'd0;
        out_reg_2         = 5'd0;
        out_reg_3         = 5'd0;
        out_imm_valid     = 1'b0;
        out_imm_val       = 32'd0;
        if (!w_empty) begin
            out_valid         = 1'b1;
            out_operator_type = r_op_mem[r_rd_ptr];
            out_reg_1         = r_rs1_mem[r_rd_ptr];
            out_reg_2         = r_rs2_mem[r_rd_ptr];
            out_reg_3         = r_rd_mem[r_rd_ptr];
            out_imm_valid     = r_immv_mem[r_rd_ptr];
            out_imm_val       = r_imm_mem[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire
